// File: rtl/divide_sequencer.sv
// divide_sequencer: sequential unsigned restoring divider.
// Produces one quotient bit per clock over n clocks, using a start/ready
// handshake. A zero divisor skips iteration and reports div_zero instead.
module divide_sequencer #(
   parameter int n = 4
) (
   input  logic         clock,
   input  logic         n_reset,
   input  logic         start,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder,
   output logic         ready,
   output logic         busy,
   output logic         div_zero
);

   localparam int CW = $clog2(n);
   localparam logic [CW-1:0] COUNT_INIT = CW'(n - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIVIDING = 2'd1,
      STOPPED  = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic [n:0]    a_reg, a_next;      // partial remainder, one guard bit
   logic [n-1:0]  q_reg, q_next;      // dividend shifting out, quotient shifting in
   logic [n-1:0]  d_reg, d_next;      // divisor latched at acceptance
   logic          dz_reg, dz_next;

   // Shift of {A,Q}; A[n] is always 0 here, so dropping it loses nothing.
   logic [2*n:0]  shifted;
   logic [n:0]    s_hi;
   logic [n-1:0]  s_lo;
   logic [n:0]    trial;

   // Datapath for one restoring step: shift, then trial-subtract the divisor.
   always_comb begin
      shifted = {a_reg, q_reg} << 1;
      s_hi    = shifted[2*n:n];
      s_lo    = shifted[n-1:0];
      trial   = s_hi - {1'b0, d_reg};
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_reg <= IDLE;
         count_reg <= COUNT_INIT;
         a_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         a_reg     <= a_next;
         q_reg     <= q_next;
         d_reg     <= d_next;
         dz_reg    <= dz_next;
      end
   end

   // Next-state and register-update logic; everything holds by default.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      a_next     = a_reg;
      q_next     = q_reg;
      d_next     = d_reg;
      dz_next    = dz_reg;
      case (state_reg)
         IDLE, STOPPED: begin
            if (start) begin
               d_next     = divisor;
               q_next     = dividend;
               a_next     = '0;
               count_next = COUNT_INIT;
               if (divisor != '0) begin
                  dz_next    = 1'b0;
                  state_next = DIVIDING;
               end else begin
                  // Divide by zero: report all-ones quotient, dividend as remainder.
                  dz_next    = 1'b1;
                  q_next     = '1;
                  a_next     = {1'b0, dividend};
                  state_next = STOPPED;
               end
            end
         end
         DIVIDING: begin
            if (!trial[n]) begin
               a_next = trial;
               q_next = s_lo | n'(1);
            end else begin
               a_next = s_hi;
               q_next = s_lo;
            end
            count_next = count_reg - CW'(1);
            if (count_reg == '0) begin
               state_next = STOPPED;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign quotient  = q_reg;
   assign remainder = a_reg[n-1:0];
   assign ready     = (state_reg == STOPPED);
   assign busy      = (state_reg == DIVIDING);
   assign div_zero  = dz_reg & ready;

endmodule

// File: tb/tb_divide_sequencer.sv
// Scoreboard bench for divide_sequencer at n=4 and n=8.
module tb_divide_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       n_reset;

   logic       start4;
   logic [3:0] dvd4, dvs4, quo4, rem4;
   logic       rdy4, busy4, dz4;

   logic       start8;
   logic [7:0] dvd8, dvs8, quo8, rem8;
   logic       rdy8, busy8, dz8;

   divide_sequencer #(.n(4)) dut4 (
      .clock(clock), .n_reset(n_reset), .start(start4),
      .dividend(dvd4), .divisor(dvs4), .quotient(quo4), .remainder(rem4),
      .ready(rdy4), .busy(busy4), .div_zero(dz4)
   );

   divide_sequencer #(.n(8)) dut8 (
      .clock(clock), .n_reset(n_reset), .start(start8),
      .dividend(dvd8), .divisor(dvs8), .quotient(quo8), .remainder(rem8),
      .ready(rdy8), .busy(busy8), .div_zero(dz8)
   );

   typedef struct {
      int q;
      int r;
      int dz;
      int lat;
      int busyc;
   } exp_t;

   exp_t sb4[$];
   exp_t sb8[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // ---------------- monitor, n=4: checks value, latency, busy window
   logic rdy4_q = 1'b0, acc4_q = 1'b0;
   int   lat4 = 0, busyc4 = 0;
   always @(negedge clock) begin : mon4
      int   lat_now, bsy_now;
      exp_t e;
      lat_now = acc4_q ? 0 : lat4 + 1;
      bsy_now = (acc4_q ? 0 : busyc4) + (busy4 ? 1 : 0);
      if (rdy4 && (!rdy4_q || acc4_q)) begin
         if (sb4.size() == 0) begin
            check("sb4_spurious_result", 1, 0);
         end else begin
            e = sb4.pop_front();
            $display("op4 q=%0d r=%0d dz=%0d lat=%0d busy=%0d", quo4, rem4, dz4, lat_now, bsy_now);
            check("q4", int'(quo4), e.q);
            check("r4", int'(rem4), e.r);
            check("dz4", int'(dz4), e.dz);
            check("lat4", lat_now, e.lat);
            check("busy4_cycles", bsy_now, e.busyc);
         end
      end
      lat4   <= lat_now;
      busyc4 <= bsy_now;
      rdy4_q <= rdy4;
      acc4_q <= start4 && !busy4 && n_reset;
   end

   // ---------------- monitor, n=8: checks value
   logic rdy8_q = 1'b0, acc8_q = 1'b0;
   always @(negedge clock) begin : mon8
      exp_t e;
      if (rdy8 && (!rdy8_q || acc8_q)) begin
         if (sb8.size() == 0) begin
            check("sb8_spurious_result", 1, 0);
         end else begin
            e = sb8.pop_front();
            $display("op8 q=%0d r=%0d dz=%0d", quo8, rem8, dz8);
            check("q8", int'(quo8), e.q);
            check("r8", int'(rem8), e.r);
            check("dz8", int'(dz8), e.dz);
         end
      end
      rdy8_q <= rdy8;
      acc8_q <= start8 && !busy8 && n_reset;
   end

   task automatic push4(input int q, input int r, input int dz);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz;
      e.lat   = dz ? 0 : 4;
      e.busyc = dz ? 0 : 4;
      sb4.push_back(e);
   endtask

   // One n=4 operation; optionally scrambles operand inputs while busy.
   task automatic op4(input int dvd, input int dvs, input int q, input int r,
                      input int dz, input bit wiggle);
      push4(q, r, dz);
      @(posedge clock); #1;
      start4 = 1'b1; dvd4 = 4'(dvd); dvs4 = 4'(dvs);
      @(posedge clock); #1;
      start4 = 1'b0;
      for (int i = 0; i < 20 && !rdy4; i++) begin
         if (wiggle) begin
            dvd4 = 4'($urandom);
            dvs4 = 4'($urandom);
         end
         @(posedge clock); #1;
      end
      check("op4_completed", int'(rdy4), 1);
   endtask

   task automatic op8(input int dvd, input int dvs);
      exp_t e;
      e.dz = (dvs == 0) ? 1 : 0;
      e.q  = (dvs == 0) ? 255 : dvd / dvs;
      e.r  = (dvs == 0) ? dvd : dvd % dvs;
      e.lat = 0; e.busyc = 0;
      sb8.push_back(e);
      @(posedge clock); #1;
      start8 = 1'b1; dvd8 = 8'(dvd); dvs8 = 8'(dvs);
      @(posedge clock); #1;
      start8 = 1'b0;
      for (int i = 0; i < 30 && !rdy8; i++) begin
         @(posedge clock); #1;
      end
      check("op8_completed", int'(rdy8), 1);
   endtask

   // Watchdog: the run must always end.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      n_reset = 1'b0;
      start4 = 1'b0; dvd4 = '0; dvs4 = '0;
      start8 = 1'b0; dvd8 = '0; dvs8 = '0;
      #12;
      check("reset_outputs4", int'({quo4, rem4, rdy4, busy4, dz4}), 0);
      check("reset_outputs8", int'({quo8, rem8, rdy8, busy8, dz8}), 0);
      #11 n_reset = 1'b1;
      @(posedge clock); #1;
      check("idle_after_release", int'({rdy4, busy4, dz4}), 0);

      // Directed vectors, hand-computed.
      op4(13, 3, 4, 1, 0, 1'b0);
      op4(15, 1, 15, 0, 0, 1'b1);
      op4(5, 7, 0, 5, 0, 1'b1);
      op4(15, 15, 1, 0, 0, 1'b1);
      op4(9, 0, 15, 9, 1, 1'b0);
      op4(8, 2, 4, 0, 0, 1'b0);
      op4(0, 5, 0, 0, 0, 1'b0);

      // start held high: three back-to-back launches of 12/5.
      push4(2, 2, 0); push4(2, 2, 0); push4(2, 2, 0);
      @(posedge clock); #1;
      start4 = 1'b1; dvd4 = 4'd12; dvs4 = 4'd5;
      cnt = 0;
      for (int i = 0; i < 11; i++) begin
         @(posedge clock); #1;
         if (rdy4) cnt++;
      end
      start4 = 1'b0;
      check("held_start_ready_pulses", cnt, 2);
      for (int i = 0; i < 20 && !rdy4; i++) begin
         @(posedge clock); #1;
      end
      check("held_start_completed", int'(rdy4), 1);

      // Asynchronous reset two cycles into a division.
      @(posedge clock); #1;
      start4 = 1'b1; dvd4 = 4'd13; dvs4 = 4'd3;
      @(posedge clock); #1;
      start4 = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #3 n_reset = 1'b0;
      #1;
      check("midrun_reset_outputs", int'({quo4, rem4, rdy4, dz4}), 0);
      check("midrun_reset_busy", int'(busy4), 0);
      @(negedge clock); #2 n_reset = 1'b1;
      op4(7, 2, 3, 1, 0, 1'b0);

      // Exhaustive n=4 sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) op4(a, b, 15, a, 1, 1'b0);
            else        op4(a, b, a / b, a % b, 0, 1'b0);
         end
      end

      // Random n=8 sample, with some forced zero divisors.
      for (int i = 0; i < 1000; i++) begin
         int a, b;
         a = int'($urandom_range(0, 255));
         b = (i % 50 == 7) ? 0 : int'($urandom_range(0, 255));
         op8(a, b);
      end
      op8(255, 255);

      repeat (3) @(posedge clock);
      check("sb4_drained", sb4.size(), 0);
      check("sb8_drained", sb8.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/divide_sequencer.md
Name: divide_sequencer

Overview:
- Sequential unsigned restoring divider: the inverse of the team's shift-and-add multiplier sequencer. Controller and datapath in one block.
- Produces one quotient bit per clock, for n clocks.
- Uses the same start/ready handshake as the multiplier. Sits beside the multiplier in the arithmetic unit and is driven by the same top-level controller.

Parameters:
- n, 4, operand width in bits (n >= 2); also the iteration count.

Ports:
- clock  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled only in idle/stopped
- dividend  input  n  unsigned dividend; sampled on the accepting edge
- divisor  input  n  unsigned divisor; sampled on the accepting edge
- quotient  output  n  result quotient; valid while ready=1
- remainder  output  n  result remainder; valid while ready=1
- ready  output  1  result valid; high only in state stopped
- busy  output  1  high only in state dividing
- div_zero  output  1  last accepted divisor was 0; valid while ready=1

Behaviour:
- Registers:
  - present state {idle, dividing, stopped}
  - count, $clog2(n) bits
  - A, partial remainder, n+1 bits
  - Q, n bits
  - D, latched divisor, n bits
  - dz, 1 bit
- Reset (n_reset=0, asynchronous, any state, including mid-division):
  - state=idle, count=n-1, A=0, Q=0, D=0, dz=0
  - Outputs: quotient=0, remainder=0, ready=0, busy=0, div_zero=0.
- idle or stopped with start=1, at the clock edge:
  - D<=divisor, Q<=dividend, A<=0, count<=n-1.
  - If divisor!=0: dz<=0, next=dividing.
  - If divisor==0: dz<=1, Q<=all ones, A<=dividend, next=stopped (no iteration).
- idle or stopped with start=0: hold all registers.
- dividing, each edge:
  - Form S={A[n-1:0],Q}<<1, i.e. shift {A,Q} left by one.
  - T = S_hi - {1'b0,D}, computed n+1 bits wide.
  - If T[n]==0: A<=T, Q<=S_lo|1. Otherwise A<=S_hi, Q<=S_lo (restore).
  - count<=count-1.
  - If count==0, next=stopped.
  - start is ignored while dividing.
- Unused encoding: next=idle (self-recovery).
- Output mapping: quotient=Q; remainder=A[n-1:0]; ready=(state==stopped); busy=(state==dividing); div_zero=dz&ready.
- Latency:
  - Nonzero divisor accepted at edge k: busy high after edges k..k+n-1; ready high after edge k+n, i.e. exactly n cycles.
  - Divide-by-zero accepted at edge k: ready high after edge k itself.
- Results persist in stopped until the next accepted start or reset.
- start held high in stopped relaunches immediately: ready is high for exactly one cycle between back-to-back operations.
- Operand changes while busy have no effect (operands are latched).
- Invariants:
  - A[n] is 0 at every stopped entry.
  - Remainder < divisor whenever dz=0.
- Boundary conditions:
  - dividend=0 gives quotient=0, remainder=0.
  - divisor=1 gives quotient=dividend, remainder=0.
  - divisor>dividend gives quotient=0, remainder=dividend.
  - Max values (all ones / all ones) give quotient=1, remainder=0.

Test Plan:
- n=4. Reset, then start with 13/3: ready rises 4 cycles after the accepting edge; quotient=4, remainder=1, div_zero=0; busy high for exactly 4 cycles.
- 15/1 -> q=15, r=0. Then 5/7 -> q=0, r=5. Then 15/15 -> q=1, r=0. Change operand inputs every cycle while busy: results unaffected.
- 9/0 -> ready one cycle after acceptance, busy never high, div_zero=1, q=15, r=9. A following 8/2 -> div_zero=0, q=4, r=0.
- start held high continuously with 12/5: results q=2, r=2 alternate with 4-cycle busy windows; ready is a one-cycle pulse each time.
- Assert n_reset asynchronously (off-edge) two cycles into a division: outputs zero immediately, state idle. After release, 7/2 completes with q=3, r=1.
- Exhaustive sweep, n=4: all 256 dividend/divisor pairs checked against / and % (zero-divisor rule applied). Repeat a random 1000-pair sample at n=8.
